scan_seq_38: RTL and testbench

Registered scan sequencer that drives a 3:8 active-low decoder stage. It steps a 3-bit channel select across the eight decoder outputs, holding each selected channel for a programmable number of cycles. Its enable and select outputs connect directly to the decoder's `en`, `a1`, `a2` and `a3` inputs. Typical uses are LED, digit or keypad row multiplexing, in single-pass or continuous mode, with pause, abort and channel masking.

---
 rtl/scan_seq_38_if.sv | 26 ++
 rtl/scan_seq_38.sv | 127 ++++++++++++
 tb/tb_scan_seq_38.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/scan_seq_38_if.sv
// Handshake bundle between a scan controller and scan_seq_38.
// master drives the control inputs; slave is the sequencer side.
interface scan_seq_38_if;
  logic       start;
  logic       stop;
  logic       pause;
  logic       cont;
  logic [7:0] mask;
  logic       en;
  logic       a1;
  logic       a2;
  logic       a3;
  logic       busy;
  logic       wrap;
  logic       done;

  modport master (
    output start, stop, pause, cont, mask,
    input  en, a1, a2, a3, busy, wrap, done
  );

  modport slave (
    input  start, stop, pause, cont, mask,
    output en, a1, a2, a3, busy, wrap, done
  );
endinterface

// File: rtl/scan_seq_38.sv
// Registered scan sequencer driving a 3:8 active-low decoder (en, a1..a3).
// Define SCAN_MASK_EN to honour the channel mask; otherwise all 8 channels scan.
module scan_seq_38 #(
  parameter int DWELL = 4
) (
  input logic         clk,
  input logic         rst,
  scan_seq_38_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

  state_t      state;
  logic [2:0]  sel;
  logic [15:0] cnt;
  logic [7:0]  mask_q;
  logic        cont_q;
  logic        en_q;
  logic        busy_q;
  logic        wrap_q;
  logic        done_q;
  logic [7:0]  mask_eff;
  logic [3:0]  nxt;
  logic        dwell_end;

`ifdef SCAN_MASK_EN
  assign mask_eff = bus.mask;
`else
  assign mask_eff = 8'hFF;
`endif

  function automatic logic [2:0] lowest_ch(input logic [7:0] m);
    lowest_ch = 3'd0;
    for (int i = 7; i >= 0; i--)
      if (m[i]) lowest_ch = i[2:0];
  endfunction

  // Returns {found, index} of the nearest enabled channel above cur.
  function automatic logic [3:0] next_ch(input logic [7:0] m, input logic [2:0] cur);
    next_ch = 4'd0;
    for (int i = 7; i >= 0; i--)
      if ((i > int'(cur)) && m[i]) next_ch = {1'b1, i[2:0]};
  endfunction

  assign nxt       = next_ch(mask_q, sel);
  assign dwell_end = (cnt == 16'(DWELL - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      sel    <= 3'd0;
      cnt    <= 16'd0;
      mask_q <= 8'd0;
      cont_q <= 1'b0;
      en_q   <= 1'b0;
      busy_q <= 1'b0;
      wrap_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      wrap_q <= 1'b0;
      done_q <= 1'b0;
      if (bus.stop) begin
        state  <= IDLE;
        en_q   <= 1'b0;
        busy_q <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (!bus.pause && bus.start && (mask_eff != 8'd0)) begin
              mask_q <= mask_eff;
              cont_q <= bus.cont;
              sel    <= lowest_ch(mask_eff);
              cnt    <= 16'd0;
              state  <= RUN;
              en_q   <= 1'b1;
              busy_q <= 1'b1;
            end
          end
          RUN: begin
            if (bus.pause) begin
              state <= PAUSE;
              en_q  <= 1'b0;
            end else if (dwell_end) begin
              cnt <= 16'd0;
              if (nxt[3]) begin
                sel <= nxt[2:0];
              end else begin
                // Pass complete: single-pass ends holding the last channel.
                wrap_q <= 1'b1;
                if (cont_q) begin
                  sel <= lowest_ch(mask_q);
                end else begin
                  state  <= IDLE;
                  done_q <= 1'b1;
                  en_q   <= 1'b0;
                  busy_q <= 1'b0;
                end
              end
            end else begin
              cnt <= cnt + 16'd1;
            end
          end
          PAUSE: begin
            if (!bus.pause) begin
              state <= RUN;
              en_q  <= 1'b1;
            end
          end
          default: begin
            state  <= IDLE;
            en_q   <= 1'b0;
            busy_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.en   = en_q;
  assign bus.a1   = sel[2];
  assign bus.a2   = sel[1];
  assign bus.a3   = sel[0];
  assign bus.busy = busy_q;
  assign bus.wrap = wrap_q;
  assign bus.done = done_q;

endmodule

// File: tb/tb_scan_seq_38.sv
// Bench for scan_seq_38: directed scenarios plus random traffic against a
// channel-list reference model of the scan.
module tb_scan_seq_38;
  localparam int DWELL = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  scan_seq_38_if bus();

  scan_seq_38 #(.DWELL(DWELL)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference model: ordered list of enabled channels, position and remaining dwell.
  bit m_busy, m_run, m_cont, m_wrap, m_done;
  int m_sel, pos, left;
  int chans[$];

  function automatic logic [7:0] eff_mask(input logic [7:0] m);
`ifdef SCAN_MASK_EN
    return m;
`else
    return m | 8'hFF;
`endif
  endfunction

  task automatic reset_model();
    m_busy = 0; m_run = 0; m_cont = 0; m_wrap = 0; m_done = 0;
    m_sel = 0; pos = 0; left = 0;
    chans.delete();
  endtask

  task automatic model_step();
    logic [7:0] em;
    em = eff_mask(bus.mask);
    m_wrap = 0;
    m_done = 0;
    if (bus.stop) begin
      m_busy = 0;
      m_run  = 0;
    end else if (!m_busy) begin
      if (!bus.pause && bus.start && em != 8'd0) begin
        chans.delete();
        for (int i = 0; i < 8; i++) if (em[i]) chans.push_back(i);
        pos = 0; left = DWELL; m_sel = chans[0];
        m_cont = bus.cont; m_busy = 1; m_run = 1;
      end
    end else if (m_run) begin
      if (bus.pause) m_run = 0;
      else begin
        left--;
        if (left == 0) begin
          left = DWELL;
          if (pos + 1 < chans.size()) begin
            pos++;
            m_sel = chans[pos];
          end else begin
            m_wrap = 1;
            if (m_cont) begin
              pos = 0;
              m_sel = chans[0];
            end else begin
              m_busy = 0; m_run = 0; m_done = 1;
            end
          end
        end
      end
    end else if (!bus.pause) begin
      m_run = 1;
    end
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string where);
    check({where, ".en"},   {7'd0, bus.en},   {7'd0, logic'(m_busy && m_run)});
    check({where, ".sel"},  {5'd0, bus.a1, bus.a2, bus.a3}, 8'(m_sel));
    check({where, ".busy"}, {7'd0, bus.busy}, {7'd0, logic'(m_busy)});
    check({where, ".wrap"}, {7'd0, bus.wrap}, {7'd0, logic'(m_wrap)});
    check({where, ".done"}, {7'd0, bus.done}, {7'd0, logic'(m_done)});
  endtask

  task automatic cyc(input string where, input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      model_step();
      #1;
      check_all(where);
    end
  endtask

  initial begin
    bus.start = 0; bus.stop = 0; bus.pause = 0; bus.cont = 0; bus.mask = 8'h00;
    reset_model();
    #3;
    check_all("reset");
    @(posedge clk);
    #1;
    rst = 0;

    // Single pass over all channels.
    bus.start = 1; bus.mask = 8'hFF; bus.cont = 0;
    cyc("single", 1);
    bus.start = 0;
    cyc("single", 40);

    // Masked continuous scan.
    bus.start = 1; bus.mask = 8'b1010_0100; bus.cont = 1;
    cyc("cont", 1);
    bus.start = 0; bus.mask = 8'h03; bus.cont = 0;
    cyc("cont", 40);
    bus.stop = 1;
    cyc("cont_stop", 1);
    bus.stop = 0;

    // Pause two cycles into channel 3.
    bus.start = 1; bus.mask = 8'hFF; bus.cont = 1;
    cyc("pause", 1);
    bus.start = 0;
    cyc("pause", 14);
    bus.pause = 1;
    cyc("pause_hold", 5);
    bus.pause = 0;
    cyc("pause_rel", 8);
    bus.stop = 1;
    cyc("pause_stop", 1);
    bus.stop = 0;

    // Abort during channel 6, then immediate re-arm.
    bus.start = 1; bus.mask = 8'hFF; bus.cont = 1;
    cyc("abort", 1);
    bus.start = 0;
    cyc("abort", 25);
    bus.stop = 1; bus.start = 1;
    cyc("abort_stop", 1);
    bus.stop = 0;
    cyc("abort_rearm", 1);
    bus.start = 0;
    cyc("abort_run", 10);
    bus.stop = 1;
    cyc("abort_end", 1);
    bus.stop = 0;

    // Empty mask, then single channel 4.
    bus.start = 1; bus.mask = 8'h00; bus.cont = 0;
    cyc("mask0", 3);
    bus.mask = 8'h10;
    cyc("single_ch", 1);
    bus.start = 0;
    cyc("single_ch", 40);

    // Random traffic.
    for (int r = 0; r < 600; r++) begin
      bus.start = ($urandom_range(0, 5) == 0);
      bus.stop  = ($urandom_range(0, 40) == 0);
      bus.pause = ($urandom_range(0, 9) == 0);
      bus.cont  = $urandom_range(0, 1);
      bus.mask  = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom_range(0, 255));
      cyc("rand", 1);
    end
    bus.start = 0; bus.stop = 0; bus.pause = 0;

    // Asynchronous reset in the middle of a scan.
    bus.start = 1; bus.mask = 8'hFF; bus.cont = 1;
    cyc("areset", 1);
    bus.start = 0;
    cyc("areset", 9);
    rst = 1;
    reset_model();
    #1;
    check_all("areset_async");
    @(posedge clk);
    #1;
    rst = 0;
    cyc("after_reset", 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
